// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from the VGA timing generator
// to the downstream pixel/colour stage and LED.
interface vga_timing_gen_if;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;
    logic       blink;

    modport master (
        output hsync, vsync, de, x, y,
        output line_start, frame_start, blink
    );

    modport slave (
        input hsync, vsync, de, x, y,
        input line_start, frame_start, blink
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v scan counters, registered sync/de/coords,
// line/frame pulses and a frame-rate LED heartbeat.
module vga_timing_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    vga_timing_gen_if.master vo
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_DE   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_S0   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_S1   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_DE   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_S0   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_S1   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;
    logic          blink_q, blink_d;

    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        fcnt_d  = fcnt_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        de_d    = de_q;
        x_d     = x_q;
        y_d     = y_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        blink_d = blink_q;
        if (en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            de_d = (h_q < H_DE) && (v_q < V_DE);
            x_d  = de_d ? 10'(h_q) : '0;
            y_d  = de_d ? 10'(v_q) : '0;
            hs_d = (h_q >= H_S0 && h_q < H_S1) ? HS_POL : ~HS_POL;
            // vsync only moves at line start so its edges stay line-aligned
            if (h_q == '0)
                vs_d = (v_q >= V_S0 && v_q < V_S1) ? VS_POL : ~VS_POL;
            ls_d = (h_q == '0);
            fs_d = (h_q == '0) && (v_q == '0);
            if (fs_d) begin
                if (fcnt_q == F_LAST) begin
                    fcnt_d  = '0;
                    blink_d = ~blink_q;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            fcnt_q  <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            fcnt_q  <= fcnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            blink_q <= blink_d;
        end
    end

    assign vo.hsync       = hs_q;
    assign vo.vsync       = vs_q;
    assign vo.de          = de_q;
    assign vo.x           = x_q;
    assign vo.y           = y_q;
    assign vo.line_start  = ls_q;
    assign vo.frame_start = fs_q;
    assign vo.blink       = blink_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing against a scan model,
// plus a tiny-raster instance for frame period and heartbeat.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, en0, rst1, en1;

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();

    vga_timing_gen u0 (
        .clk   (clk),
        .rst_n (rst0),
        .en    (en0),
        .vo    (if0)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .BLINK_FRAMES(2)
    ) u1 (
        .clk   (clk),
        .rst_n (rst1),
        .en    (en1),
        .vo    (if1)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    // {hs, vs, de, ls, fs, blink, x[9:0], y[9:0]}
    function automatic logic [31:0] obs0();
        return 32'({if0.hsync, if0.vsync, if0.de, if0.line_start,
                    if0.frame_start, if0.blink, if0.x, if0.y});
    endfunction

    int          mh, mv;
    logic        e_vs;
    logic [31:0] exp0;

    task automatic mdl_reset();
        mh   = 0;
        mv   = 0;
        e_vs = 1'b1;
        exp0 = 32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});
    endtask

    task automatic mdl_emit();
        logic hs, de, ls, fs;
        logic [9:0] ex, ey;
        de = (mh < 640) && (mv < 480);
        ex = de ? 10'(mh) : 10'd0;
        ey = de ? 10'(mv) : 10'd0;
        hs = !(mh >= 656 && mh < 752);
        if (mh == 0) e_vs = !(mv >= 490 && mv < 492);
        ls = (mh == 0);
        fs = (mh == 0) && (mv == 0);
        exp0 = 32'({hs, e_vs, de, ls, fs, 1'b0, ex, ey});
        mh++;
        if (mh == 800) begin
            mh = 0;
            mv = (mv + 1) % 525;
        end
    endtask

    task automatic step0(input bit e, input string tag);
        en0 = e;
        @(posedge clk);
        if (e) mdl_emit();
        else begin
            exp0[22] = 1'b0;
            exp0[21] = 1'b0;
        end
        #1;
        chk(tag, obs0(), exp0);
    endtask

    initial begin
        int de_cnt, hs_cnt, ls_cnt, hs_first, hs_last;
        int ls_pos[$];
        int wide;
        logic prev_ls;

        rst0 = 1'b0; en0 = 1'b1;
        rst1 = 1'b0; en1 = 1'b0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst hsync", 32'(if0.hsync), 1);
        chk("rst vsync", 32'(if0.vsync), 1);
        chk("rst de", 32'(if0.de), 0);
        chk("rst x", 32'(if0.x), 0);
        chk("rst y", 32'(if0.y), 0);
        chk("rst blink", 32'(if0.blink), 0);
        chk("rst ls", 32'(if0.line_start), 0);
        chk("rst fs", 32'(if0.frame_start), 0);

        rst0 = 1'b1;
        step0(1'b1, "first");
        chk("first fs", 32'(if0.frame_start), 1);
        chk("first ls", 32'(if0.line_start), 1);
        chk("first de", 32'(if0.de), 1);
        chk("first x", 32'(if0.x), 0);
        chk("first y", 32'(if0.y), 0);

        // two full lines with en held high; sample k shows h=k%800
        de_cnt = 1; hs_cnt = 0; ls_cnt = 1;
        hs_first = -1; hs_last = -1;
        for (int k = 1; k < 1600; k++) begin
            step0(1'b1, "line");
            if (if0.de) de_cnt++;
            if (if0.line_start) ls_cnt++;
            if (!if0.hsync) begin
                hs_cnt++;
                if (k < 800 && hs_first < 0) hs_first = k;
                if (k < 800) hs_last = k;
            end
            if (k == 800) chk("line1 y", 32'(if0.y), 1);
        end
        chk("de cycles", 32'(de_cnt), 1280);
        chk("hs cycles", 32'(hs_cnt), 192);
        chk("ls count", 32'(ls_cnt), 2);
        chk("hs first", 32'(hs_first), 656);
        chk("hs last", 32'(hs_last), 751);

        // en on alternate cycles doubles every period
        prev_ls = 1'b0; wide = 0;
        for (int k = 0; k < 3200; k++) begin
            step0(k[0], "half");
            if (if0.line_start) ls_pos.push_back(k);
            if (if0.line_start && prev_ls) wide++;
            prev_ls = if0.line_start;
        end
        chk("half ls count", 32'(ls_pos.size()), 2);
        if (ls_pos.size() == 2)
            chk("half ls period", 32'(ls_pos[1] - ls_pos[0]), 1600);
        chk("half ls wide", 32'(wide), 0);

        // async reset in the middle of a visible line
        for (int k = 0; k < 300; k++) step0(1'b1, "pre-rst");
        chk("pre-rst x", 32'(if0.x), 299);
        #3;
        rst0 = 1'b0;
        #1;
        chk("async de", 32'(if0.de), 0);
        chk("async x", 32'(if0.x), 0);
        chk("async y", 32'(if0.y), 0);
        chk("async hsync", 32'(if0.hsync), 1);
        chk("async vsync", 32'(if0.vsync), 1);
        mdl_reset();
        @(posedge clk);
        #1;
        chk("held rst", obs0(), exp0);
        rst0 = 1'b1;
        step0(1'b1, "restart");
        chk("restart fs", 32'(if0.frame_start), 1);
        for (int k = 1; k < 800; k++) step0(1'b1, "restart");
        en0 = 1'b0;

        // tiny raster: H_TOTAL=8, V_TOTAL=6, frame every 48 en cycles
        begin
            int fs_pos[$];
            logic bl_at_fs[$];
            logic bl_tab[6];
            int d_cnt, h_cnt, v_cnt, l_cnt, viol;
            logic prev_vs, prev_bl;
            bl_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            d_cnt = 0; h_cnt = 0; v_cnt = 0; l_cnt = 0; viol = 0;
            prev_vs = 1'b1; prev_bl = 1'b0;
            rst1 = 1'b1;
            en1 = 1'b1;
            for (int k = 0; k < 300; k++) begin
                @(posedge clk);
                #1;
                if (if1.frame_start) begin
                    fs_pos.push_back(k);
                    bl_at_fs.push_back(if1.blink);
                end
                if (k == 47) chk("s blink pre2", 32'(if1.blink), 0);
                if (k < 48) begin
                    if (if1.de) d_cnt++;
                    if (!if1.hsync) h_cnt++;
                    if (!if1.vsync) v_cnt++;
                    if (if1.line_start) l_cnt++;
                end
                if (if1.vsync != prev_vs && !if1.line_start) viol++;
                if (if1.blink != prev_bl && !if1.frame_start) viol++;
                prev_vs = if1.vsync;
                prev_bl = if1.blink;
            end
            chk("s fs count", 32'(fs_pos.size()), 7);
            if (fs_pos.size() >= 2) begin
                chk("s fs first", 32'(fs_pos[0]), 0);
                chk("s fs period", 32'(fs_pos[1] - fs_pos[0]), 48);
            end
            for (int i = 0; i < 6; i++)
                if (i < bl_at_fs.size())
                    chk($sformatf("s blink fs%0d", i + 1),
                        32'(bl_at_fs[i]), 32'(bl_tab[i]));
            chk("s de cycles", 32'(d_cnt), 12);
            chk("s hs cycles", 32'(h_cnt), 12);
            chk("s vs cycles", 32'(v_cnt), 8);
            chk("s ls count", 32'(l_cnt), 6);
            chk("s edge align", 32'(viol), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator for the VGA output path on the iCE40 boards (icestick, Icezum Alhambra). It produces HSYNC/VSYNC, the active-video enable and pixel coordinates that feed the downstream pixel/colour stage. It also drives a frame-rate heartbeat that goes to a board LED as a visible liveness indicator. Runs in the pixel clock domain, gated by a clock enable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hsync
VS_POL, 0, asserted level of vsync
BLINK_FRAMES, 30, frames per heartbeat toggle (>=1)

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
en  input  1  pixel enable; one pixel position is emitted per cycle with en=1
hsync  output  1  horizontal sync, level HS_POL when asserted
vsync  output  1  vertical sync, level VS_POL when asserted
de  output  1  active-video enable
x  output  10  pixel column, valid when de=1, else 0
y  output  10  pixel row, valid when de=1, else 0
line_start  output  1  one-cycle pulse at h=0 of every line
frame_start  output  1  one-cycle pulse at h=0, v=0
blink  output  1  heartbeat for LED

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All state is cleared on rst_n falling, independent of clk.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Internal counters: h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1. Counter widths are derived from the totals via $clog2.
- Counter advance (only on cycles with en=1):
  - h increments and wraps to 0 after H_TOTAL-1.
  - On the h wrap, v increments and wraps to 0 after V_TOTAL-1.
  - With en=0, h and v hold.
- Emission: on an en=1 cycle, the current (h,v) is decoded into the output registers and appears at the outputs on the next clk edge. Latency is 1 cycle. All outputs are registered and mutually aligned.
- Decode rules:
  - de = (h < H_ACTIVE) && (v < V_ACTIVE).
  - x = h when de=1, else 0. y = v when de=1, else 0.
  - hsync = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. vsync changes only when h=0, so it is line-aligned.
  - line_start = (h==0). frame_start = (h==0 && v==0).
- With en=0: hsync, vsync, de, x, y and blink hold their values. line_start and frame_start are forced to 0, so each pulse lasts exactly one clk.
- Heartbeat: frame counter fcnt, 0..BLINK_FRAMES-1. On each emitted frame start:
  - if fcnt==BLINK_FRAMES-1, then fcnt=0 and blink toggles;
  - else fcnt increments.
  - The blink change is visible in the same cycle as the frame_start output pulse.
- Reset values: h=v=fcnt=0, hsync=~HS_POL, vsync=~VS_POL, de=0, x=y=0, line_start=frame_start=0, blink=0.
- After reset release, the first en=1 cycle emits (0,0). The next cycle shows de=1, x=0, y=0, line_start=1, frame_start=1.
- Reset mid-frame: outputs drop to reset values immediately (asynchronous). Scanning restarts at (0,0) and emits no partial line.
- The block must elaborate correctly for any parameter set with all widths >=1 and totals <=1024.

Test Plan:
- Reset: hold rst_n=0 with en=1 -> hsync=1, vsync=1, de=0, x=y=0, blink=0. First en cycle after release -> next cycle shows frame_start=1, line_start=1, de=1, x=0, y=0.
- Default line, en=1 continuously -> de high for 640 cycles (x 0..639), low for 160. hsync low for x-positions 656..751 (96 cycles). line_start period is 800 cycles.
- Default frame -> frame_start period is 420000 cycles. de low on lines 480..524. vsync low exactly on lines 490..491 (1600 cycles), with edges coinciding with line_start.
- en toggled every other cycle -> all periods double (line_start every 1600 clk). frame_start and line_start stay 1 clk wide. No position skipped or repeated.
- Async reset: assert rst_n=0 at h=300, v=200 between clk edges -> outputs reach reset values before the next edge. After release, the frame restarts at (0,0).
- Small params (H 4/1/2/1, V 3/1/1/1, BLINK_FRAMES=2) -> H_TOTAL=8, V_TOTAL=6, frame every 48 en cycles. blink toggles at the 2nd, 4th and 6th frame_start.
